// File: rtl/ladybird_mem_ram.sv
// Single-port word RAM with byte strobes, a fixed-latency read pipeline,
// optional byte-lane swap and an optional zero-fill sequence after reset.
module ladybird_mem_ram #(
  parameter int XLEN           = 32,
  parameter int ADDR_W         = 10,
  parameter int READ_LATENCY   = 2,
  parameter int BYTE_SWAP      = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              gnt,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN/8-1:0] wstrb,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata,
  output logic              data_gnt,
  output logic              busy
);

  localparam int NB    = XLEN / 8;
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_READY;

  function automatic logic [XLEN-1:0] swap_word(input logic [XLEN-1:0] w);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[8*i +: 8] = w[8*(NB-1-i) +: 8];
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] swap_strb(input logic [NB-1:0] s);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) begin
      r[i] = s[NB-1-i];
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [XLEN-1:0]   mem_q [DEPTH];
  logic [READ_LATENCY-1:0] vld_q;
  logic [XLEN-1:0]   dat_q [READ_LATENCY];

  logic [ADDR_W-1:0] idx_s;
  logic [XLEN-1:0]   arr_wdata_s;
  logic [NB-1:0]     arr_wstrb_s;
  logic              accept_s, wr_s, rd_s, fill_s;
  logic              unused_addr_s;

  assign idx_s         = addr[ADDR_W+1:2];
  assign unused_addr_s = ^{addr[XLEN-1:ADDR_W+2], addr[1:0]};

  // Port-to-array lane mapping and request decode
  always_comb begin
    if (BYTE_SWAP != 0) begin
      arr_wdata_s = swap_word(wdata);
      arr_wstrb_s = swap_strb(wstrb);
    end else begin
      arr_wdata_s = wdata;
      arr_wstrb_s = wstrb;
    end
    accept_s = req & gnt;
    wr_s     = accept_s & (|wstrb);
    rd_s     = accept_s & ~(|wstrb);
    fill_s   = (state_q == ST_INIT) & ~rst;
  end

  // FSM state and fill counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // FSM next state: INIT walks every word once, then READY forever
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    case (state_q)
      ST_INIT: begin
        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        if (fill_cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = RST_STATE;
    endcase
  end

  // FSM outputs; rst masks gnt immediately, busy follows the reset state
  always_comb begin
    case (state_q)
      ST_INIT: begin
        gnt  = 1'b0;
        busy = 1'b1;
      end
      ST_READY: begin
        gnt  = ~rst;
        busy = 1'b0;
      end
      default: begin
        gnt  = 1'b0;
        busy = 1'b0;
      end
    endcase
  end

  // Array write port: zero-fill has priority, otherwise strobed port writes
  always_ff @(posedge clk) begin
    if (fill_s) begin
      mem_q[fill_cnt_q] <= '0;
    end else if (wr_s) begin
      for (int b = 0; b < NB; b++) begin
        if (arr_wstrb_s[b]) begin
          mem_q[idx_s][8*b +: 8] <= arr_wdata_s[8*b +: 8];
        end
      end
    end
  end

  // Read pipeline; reset flushes every in-flight read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= rd_s;
      dat_q[0] <= mem_q[idx_s];
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign data_gnt = vld_q[READ_LATENCY-1];

  // Read data is forced to zero outside the valid pulse
  always_comb begin
    rdata = '0;
    if (vld_q[READ_LATENCY-1]) begin
      if (BYTE_SWAP != 0) begin
        rdata = swap_word(dat_q[READ_LATENCY-1]);
      end else begin
        rdata = dat_q[READ_LATENCY-1];
      end
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: tb/tb_ladybird_mem_ram.sv
// Directed bench: three instances (default-ish, latency 3 with byte swap,
// latency 1 without clear) driven one at a time with hand-computed vectors.
module tb_ladybird_mem_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_s   [3];
  logic        req_s   [3];
  logic        gnt_s   [3];
  logic [31:0] addr_s  [3];
  logic [3:0]  wstrb_s [3];
  logic [31:0] wdata_s [3];
  logic [31:0] rdata_s [3];
  logic        dg_s    [3];
  logic        busy_s  [3];

  int total = 0;
  int bad   = 0;
  int lat [3] = '{2, 3, 1};

  logic        il_dg [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] il_rd [6] = '{32'h0, 32'h0, 32'hAA223344, 32'h0, 32'h12345678, 32'h0};
  logic        st_dg [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] st_rd [7] = '{32'h0, 32'h0, 32'h0, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'h0};

  ladybird_mem_ram #(.XLEN(32), .ADDR_W(4), .READ_LATENCY(2), .BYTE_SWAP(0), .CLEAR_ON_RESET(1)) u_a (
    .clk(clk), .rst(rst_s[0]), .req(req_s[0]), .gnt(gnt_s[0]), .addr(addr_s[0]),
    .wstrb(wstrb_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]), .data_gnt(dg_s[0]), .busy(busy_s[0]));

  ladybird_mem_ram #(.XLEN(32), .ADDR_W(4), .READ_LATENCY(3), .BYTE_SWAP(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst(rst_s[1]), .req(req_s[1]), .gnt(gnt_s[1]), .addr(addr_s[1]),
    .wstrb(wstrb_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]), .data_gnt(dg_s[1]), .busy(busy_s[1]));

  ladybird_mem_ram #(.XLEN(32), .ADDR_W(4), .READ_LATENCY(1), .BYTE_SWAP(0), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .rst(rst_s[2]), .req(req_s[2]), .gnt(gnt_s[2]), .addr(addr_s[2]),
    .wstrb(wstrb_s[2]), .wdata(wdata_s[2]), .rdata(rdata_s[2]), .data_gnt(dg_s[2]), .busy(busy_s[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] w);
    req_s[d]   = r;
    addr_s[d]  = a;
    wstrb_s[d] = s;
    wdata_s[d] = w;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int d, input logic [31:0] a, input logic [3:0] s, input logic [31:0] w);
    chk("wr_gnt", 32'(gnt_s[d]), 32'd1);
    drive(d, 1'b1, a, s, w);
    step();
    drive(d, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic rd(input int d, input logic [31:0] a, input logic [31:0] exp, input string tag);
    chk({tag, "_gnt"}, 32'(gnt_s[d]), 32'd1);
    drive(d, 1'b1, a, 4'h0, 32'h0);
    step();
    drive(d, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 1; i < lat[d]; i++) begin
      chk({tag, "_early"}, 32'(dg_s[d]), 32'd0);
      step();
    end
    chk({tag, "_dg"}, 32'(dg_s[d]), 32'd1);
    chk(tag, rdata_s[d], exp);
    step();
    chk({tag, "_dgoff"}, 32'(dg_s[d]), 32'd0);
    chk({tag, "_rd0"}, rdata_s[d], 32'h0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      rst_s[d] = 1'b1;
      drive(d, 1'b0, 32'h0, 4'h0, 32'h0);
    end
    step(); step(); step();
    chk("rst_gnt_a",  32'(gnt_s[0]),  32'd0);
    chk("rst_dg_a",   32'(dg_s[0]),   32'd0);
    chk("rst_rd_a",   rdata_s[0],     32'h0);
    chk("rst_busy_a", 32'(busy_s[0]), 32'd1);
    chk("rst_busy_b", 32'(busy_s[1]), 32'd1);
    chk("rst_busy_c", 32'(busy_s[2]), 32'd0);
    chk("rst_gnt_c",  32'(gnt_s[2]),  32'd0);

    for (int d = 0; d < 3; d++) rst_s[d] = 1'b0;
    #1;
    chk("rel_gnt_c",  32'(gnt_s[2]),  32'd1);
    chk("rel_busy_c", 32'(busy_s[2]), 32'd0);

    // 16 fill cycles; a write offered in the last one must be ignored
    for (int i = 0; i < 16; i++) begin
      chk("fill_busy", 32'(busy_s[0]), 32'd1);
      chk("fill_gnt",  32'(gnt_s[0]),  32'd0);
      if (i == 15) drive(0, 1'b1, 32'h0, 4'hF, 32'hFFFFFFFF);
      step();
    end
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("ready_gnt",  32'(gnt_s[0]),  32'd1);
    chk("ready_busy", 32'(busy_s[0]), 32'd0);
    chk("ready_gnt_b", 32'(gnt_s[1]), 32'd1);

    rd(0, 32'h3C, 32'h0, "clr_3c");
    rd(0, 32'h0,  32'h0, "ign_init");
    wr(0, 32'h8, 4'hF, 32'h11223344);
    wr(0, 32'h8, 4'h8, 32'hAA000000);
    rd(0, 32'h8, 32'hAA223344, "bytewr");
    wr(0, 32'h40, 4'hF, 32'hDEADBEEF);
    rd(0, 32'h0,  32'hDEADBEEF, "alias_raw");
    rd(0, 32'h43, 32'hDEADBEEF, "lowbits");
    wr(0, 32'h4, 4'b0101, 32'h55667788);
    rd(0, 32'hC4, 32'h00660088, "strb_alias");

    // read, write, read back-to-back: fixed latency kept across the write
    drive(0, 1'b1, 32'h8, 4'h0, 32'h0);
    for (int c = 1; c < 6; c++) begin
      step();
      if (c == 1)      drive(0, 1'b1, 32'hC, 4'hF, 32'h12345678);
      else if (c == 2) drive(0, 1'b1, 32'hC, 4'h0, 32'h0);
      else             drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk("il_dg", 32'(dg_s[0]), 32'(il_dg[c]));
      chk("il_rd", rdata_s[0], il_rd[c]);
    end

    // reset one cycle after a read is accepted
    drive(0, 1'b1, 32'h8, 4'h0, 32'h0);
    step();
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    rst_s[0] = 1'b1;
    #1;
    chk("fl_dg",   32'(dg_s[0]),   32'd0);
    chk("fl_gnt",  32'(gnt_s[0]),  32'd0);
    chk("fl_rd",   rdata_s[0],     32'h0);
    chk("fl_busy", 32'(busy_s[0]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_dg_hold", 32'(dg_s[0]), 32'd0);
    end
    rst_s[0] = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      chk("refill_busy", 32'(busy_s[0]), 32'd1);
      step();
    end
    chk("refill_gnt", 32'(gnt_s[0]), 32'd1);
    rd(0, 32'h8, 32'h0, "refill_rd");

    // latency-3 streaming on the swapped instance
    wr(1, 32'h0, 4'hF, 32'hA0A1A2A3);
    wr(1, 32'h4, 4'hF, 32'hB0B1B2B3);
    wr(1, 32'h8, 4'hF, 32'hC0C1C2C3);
    drive(1, 1'b1, 32'h0, 4'h0, 32'h0);
    for (int c = 1; c < 7; c++) begin
      step();
      if (c <= 2) drive(1, 1'b1, 32'(4 * c), 4'h0, 32'h0);
      else        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
      chk("st_dg", 32'(dg_s[1]), 32'(st_dg[c]));
      chk("st_rd", rdata_s[1], st_rd[c]);
    end

    wr(1, 32'h10, 4'b0001, 32'h01020304);
    chk("swap_arr", u_b.mem_q[4], 32'h04000000);
    rd(1, 32'h10, 32'h00000004, "swap_rd");

    // latency 1, no clear: contents survive reset
    wr(2, 32'h20, 4'hF, 32'hCAFEF00D);
    rd(2, 32'h20, 32'hCAFEF00D, "lat1");
    rst_s[2] = 1'b1;
    #1;
    chk("c_rst_busy", 32'(busy_s[2]), 32'd0);
    chk("c_rst_gnt",  32'(gnt_s[2]),  32'd0);
    step(); step();
    rst_s[2] = 1'b0;
    #1;
    chk("c_rel_gnt", 32'(gnt_s[2]), 32'd1);
    rd(2, 32'h20, 32'hCAFEF00D, "keep");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
